motor_cmd_ctrl: RTL

MOTOR_CMD_CTRL -- requirements
Module: motor_cmd_ctrl

---
 rtl/motor_cmd_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/motor_cmd_ctrl.sv
// ============================================================================
// Module   : motor_cmd_ctrl
// Brief    : Remote-command motor controller with speed ramp, brake,
//            reversal dead time and steering pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module motor_cmd_ctrl #(
  parameter int RAMP_DIV     = 4,
  parameter int SPEED_INIT   = 128,
  parameter int SPEED_STEP   = 16,
  parameter int SPEED_MIN    = 32,
  parameter int DEAD_CYCLES  = 8,
  parameter int STEER_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  output logic       enable,
  output logic       direction,
  output logic [7:0] duty_cycle,
  output logic       drv_rst,
  output logic       steer_left,
  output logic       steer_right,
  output logic [1:0] state,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2,
    DEAD  = 2'd3
  } state_t;

  localparam logic [7:0] CODE_LEFT  = 8'hA2;
  localparam logic [7:0] CODE_RIGHT = 8'hE2;
  localparam logic [7:0] CODE_DEC   = 8'hE0;
  localparam logic [7:0] CODE_INC   = 8'hA8;
  localparam logic [7:0] CODE_START = 8'hC2;
  localparam logic [7:0] CODE_STOP  = 8'h68;
  localparam logic [7:0] CODE_DIV   = 8'h90;
  localparam logic [7:0] CODE_RST   = 8'h8E;

  localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W  = $clog2(DEAD_CYCLES + 1);
  localparam int STEER_W = $clog2(STEER_CYCLES + 1);

  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0]  DEAD_INIT  = DEAD_W'(DEAD_CYCLES);
  localparam logic [STEER_W-1:0] STEER_INIT = STEER_W'(STEER_CYCLES);
  localparam logic [7:0]         TGT_INIT   = 8'(SPEED_INIT);
  localparam logic [7:0]         TGT_STEP   = 8'(SPEED_STEP);
  localparam logic [7:0]         TGT_MIN    = 8'(SPEED_MIN);
  localparam logic [8:0]         DEC_FLOOR  = 9'(SPEED_STEP + SPEED_MIN);

  state_t              fsm;
  logic [RAMP_W-1:0]   ramp_cnt;
  logic [DEAD_W-1:0]   dead_cnt;
  logic [STEER_W-1:0]  steer_cnt;
  logic [7:0]          target;
  logic                rev_pending;

  logic cmd_left, cmd_right, cmd_dec, cmd_inc, cmd_start;
  logic cmd_stop, cmd_div, cmd_rst, cmd_bad;
  logic tick;
  logic steer_ok;
  logic [8:0] inc_sum;
  logic [7:0] target_inc, target_dec;

  always_comb begin
    cmd_left  = 1'b0;
    cmd_right = 1'b0;
    cmd_dec   = 1'b0;
    cmd_inc   = 1'b0;
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_div   = 1'b0;
    cmd_rst   = 1'b0;
    cmd_bad   = 1'b0;
    if (cmd_valid) begin
      case (cmd_code)
        CODE_LEFT:  cmd_left  = 1'b1;
        CODE_RIGHT: cmd_right = 1'b1;
        CODE_DEC:   cmd_dec   = 1'b1;
        CODE_INC:   cmd_inc   = 1'b1;
        CODE_START: cmd_start = 1'b1;
        CODE_STOP:  cmd_stop  = 1'b1;
        CODE_DIV:   cmd_div   = 1'b1;
        CODE_RST:   cmd_rst   = 1'b1;
        default:    cmd_bad   = 1'b1;
      endcase
    end
  end

  assign tick     = (ramp_cnt == RAMP_LAST);
  assign steer_ok = (fsm != IDLE);
  assign state    = fsm;

  // Target arithmetic is carried at 9 bits so the limits clamp instead of wrapping.
  assign inc_sum    = {1'b0, target} + {1'b0, TGT_STEP};
  assign target_inc = (inc_sum > 9'd255) ? 8'hFF : inc_sum[7:0];
  assign target_dec = ({1'b0, target} < DEC_FLOOR) ? TGT_MIN : (target - TGT_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_cnt    <= '0;
      target      <= TGT_INIT;
      steer_cnt   <= '0;
      steer_left  <= 1'b0;
      steer_right <= 1'b0;
      cmd_err     <= 1'b0;
      drv_rst     <= 1'b0;
    end else if (cmd_rst) begin
      ramp_cnt    <= '0;
      target      <= TGT_INIT;
      steer_cnt   <= '0;
      steer_left  <= 1'b0;
      steer_right <= 1'b0;
      cmd_err     <= 1'b0;
      drv_rst     <= 1'b1;
    end else begin
      drv_rst  <= 1'b0;
      cmd_err  <= cmd_bad;
      ramp_cnt <= tick ? '0 : ramp_cnt + RAMP_W'(1);
      if (cmd_inc) begin
        target <= target_inc;
      end else if (cmd_dec) begin
        target <= target_dec;
      end
      if (steer_ok && cmd_left) begin
        steer_left  <= 1'b1;
        steer_right <= 1'b0;
        steer_cnt   <= STEER_INIT;
      end else if (steer_ok && cmd_right) begin
        steer_left  <= 1'b0;
        steer_right <= 1'b1;
        steer_cnt   <= STEER_INIT;
      end else if (steer_cnt != '0) begin
        steer_cnt <= steer_cnt - STEER_W'(1);
        if (steer_cnt == STEER_W'(1)) begin
          steer_left  <= 1'b0;
          steer_right <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      enable      <= 1'b0;
      direction   <= 1'b0;
      duty_cycle  <= 8'd0;
      rev_pending <= 1'b0;
      dead_cnt    <= '0;
    end else if (cmd_rst) begin
      fsm         <= IDLE;
      enable      <= 1'b0;
      direction   <= 1'b0;
      duty_cycle  <= 8'd0;
      rev_pending <= 1'b0;
      dead_cnt    <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (cmd_start) begin
            fsm    <= RUN;
            enable <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            if (duty_cycle < target) begin
              duty_cycle <= duty_cycle + 8'd1;
            end else if (duty_cycle > target) begin
              duty_cycle <= duty_cycle - 8'd1;
            end
          end
          if (cmd_stop) begin
            fsm         <= BRAKE;
            rev_pending <= 1'b0;
          end else if (cmd_div) begin
            fsm         <= BRAKE;
            rev_pending <= 1'b1;
          end
        end
        BRAKE: begin
          if (cmd_stop) begin
            rev_pending <= 1'b0;
          end
          if (tick) begin
            if (duty_cycle == 8'd0) begin
              enable <= 1'b0;
              // A stop arriving on the final tick still cancels the reversal.
              if (rev_pending && !cmd_stop) begin
                fsm         <= DEAD;
                dead_cnt    <= DEAD_INIT;
                rev_pending <= 1'b0;
              end else begin
                fsm <= IDLE;
              end
            end else begin
              duty_cycle <= duty_cycle - 8'd1;
            end
          end
        end
        DEAD: begin
          if (cmd_stop) begin
            fsm      <= IDLE;
            dead_cnt <= '0;
          end else if (dead_cnt == DEAD_W'(1)) begin
            fsm       <= RUN;
            enable    <= 1'b1;
            direction <= ~direction;
            dead_cnt  <= '0;
          end else begin
            dead_cnt <= dead_cnt - DEAD_W'(1);
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
